// File: rtl/lifo_stack_pkg.sv
// -----------------------------------------------------------------------------
// lifo_stack_pkg
// Shared definitions for the operand-stack LIFO:
//   - default data width and depth
//   - lifo_op_e: the operation requested in a cycle, decoded from {psh, pop}
//   - decode_op(): maps the two request strobes to an operation
// -----------------------------------------------------------------------------
package lifo_stack_pkg;

    localparam int LIFO_DATA_W = 8;
    localparam int LIFO_DEPTH  = 16;

    typedef enum logic [1:0] {
        OP_NONE    = 2'b00,
        OP_POP     = 2'b01,
        OP_PUSH    = 2'b10,
        OP_REPLACE = 2'b11
    } lifo_op_e;

    function automatic lifo_op_e decode_op(input logic i_psh, input logic i_pop);
        lifo_op_e w_op;
        case ({i_psh, i_pop})
            2'b10:   w_op = OP_PUSH;
            2'b01:   w_op = OP_POP;
            2'b11:   w_op = OP_REPLACE;
            default: w_op = OP_NONE;
        endcase
        return w_op;
    endfunction

endpackage

// File: rtl/lifo_stack_mem.sv
// -----------------------------------------------------------------------------
// lifo_stack_mem
// DEPTH x DATA_W register array backing the stack.
// Ports:
//   clk     in   rising-edge clock
//   i_we    in   write enable
//   i_waddr in   write address
//   i_wdata in   write data
//   i_raddr in   read address
//   o_rdata out  read data (asynchronous, combinational from i_raddr)
// Contents are not reset; the stack pointer alone defines what is valid.
// -----------------------------------------------------------------------------
module lifo_stack_mem
    import lifo_stack_pkg::*;
#(
    parameter int DATA_W = LIFO_DATA_W,
    parameter int DEPTH  = LIFO_DEPTH,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [AW-1:0]     i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [AW-1:0]     i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    // Synchronous write port
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/lifo_stack.sv
// -----------------------------------------------------------------------------
// lifo_stack
// Synchronous LIFO operand stack with a registered pop result.
// Optional feature macro: LIFO_STACK_ERR_EN adds sticky overflow/underflow.
// Ports:
//   clockSignal in   rising-edge clock
//   reset       in   asynchronous active-high reset
//   psh         in   push request (sampled on rising edge)
//   pop         in   pop request  (sampled on rising edge)
//   d_in        in   value to push
//   o           out  registered value of the last completed pop
//   popDone     out  one-cycle pulse: a pop completed this cycle
//   count       out  number of stored entries
//   empty       out  count == 0
//   full        out  count == DEPTH
//   overflow    out  (LIFO_STACK_ERR_EN) sticky: push while full, no pop
//   underflow   out  (LIFO_STACK_ERR_EN) sticky: pop while empty, no push
// -----------------------------------------------------------------------------
module lifo_stack
    import lifo_stack_pkg::*;
#(
    parameter  int DATA_W = LIFO_DATA_W,
    parameter  int DEPTH  = LIFO_DEPTH,
    localparam int PTR_W  = $clog2(DEPTH) + 1
) (
    input  logic              clockSignal,
    input  logic              reset,
    input  logic              psh,
    input  logic              pop,
    input  logic [DATA_W-1:0] d_in,
    output logic [DATA_W-1:0] o,
    output logic              popDone,
    output logic [PTR_W-1:0]  count,
    output logic              empty,
    output logic              full
`ifdef LIFO_STACK_ERR_EN
    ,
    output logic              overflow,
    output logic              underflow
`endif
);

    localparam int AW = $clog2(DEPTH);

    logic [PTR_W-1:0]  r_count;
    logic [DATA_W-1:0] r_o;
    logic              r_pop_done;

    lifo_op_e          w_op;
    logic              w_empty;
    logic              w_full;
    logic [AW-1:0]     w_top_addr;
    logic [DATA_W-1:0] w_rdata;
    logic              w_we;
    logic [AW-1:0]     w_waddr;
    logic [PTR_W-1:0]  w_count_nxt;
    logic [DATA_W-1:0] w_o_nxt;
    logic              w_done_nxt;

    assign w_op       = decode_op(psh, pop);
    assign w_empty    = (r_count == PTR_W'(0));
    assign w_full     = (r_count == PTR_W'(DEPTH));
    // Address of the current top entry; only meaningful when not empty.
    assign w_top_addr = AW'(r_count - PTR_W'(1));

    lifo_stack_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_mem (
        .clk     (clockSignal),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (d_in),
        .i_raddr (w_top_addr),
        .o_rdata (w_rdata)
    );

    // Next-state decode for pointer, pop result and completion pulse
    always_comb begin
        w_count_nxt = r_count;
        w_o_nxt     = r_o;
        w_done_nxt  = 1'b0;
        w_we        = 1'b0;
        w_waddr     = w_top_addr;
        case (w_op)
            OP_PUSH: begin
                if (!w_full) begin
                    w_we        = 1'b1;
                    w_waddr     = r_count[AW-1:0];
                    w_count_nxt = r_count + PTR_W'(1);
                end else begin
                    w_we        = 1'b0;
                end
            end
            OP_POP: begin
                // Pulse even when empty so a waiting requester is released.
                w_done_nxt = 1'b1;
                if (!w_empty) begin
                    w_o_nxt     = w_rdata;
                    w_count_nxt = r_count - PTR_W'(1);
                end else begin
                    w_o_nxt     = r_o;
                end
            end
            OP_REPLACE: begin
                w_done_nxt = 1'b1;
                if (!w_empty) begin
                    // Old top is read out while the new value overwrites it.
                    w_o_nxt = w_rdata;
                    w_we    = 1'b1;
                end else begin
                    w_o_nxt = d_in;
                end
            end
            default: begin
                w_done_nxt = 1'b0;
            end
        endcase
    end

    // State registers: occupancy, pop result and completion pulse
    always_ff @(posedge clockSignal or posedge reset) begin
        if (reset) begin
            r_count    <= '0;
            r_o        <= '0;
            r_pop_done <= 1'b0;
        end else begin
            r_count    <= w_count_nxt;
            r_o        <= w_o_nxt;
            r_pop_done <= w_done_nxt;
        end
    end

`ifdef LIFO_STACK_ERR_EN
    logic r_overflow;
    logic r_underflow;

    // Sticky error flags, cleared only by reset
    always_ff @(posedge clockSignal or posedge reset) begin
        if (reset) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_overflow  <= r_overflow  | ((w_op == OP_PUSH) && w_full);
            r_underflow <= r_underflow | ((w_op == OP_POP)  && w_empty);
        end
    end

    assign overflow  = r_overflow;
    assign underflow = r_underflow;
`endif

    assign o       = r_o;
    assign popDone = r_pop_done;
    assign count   = r_count;
    assign empty   = w_empty;
    assign full    = w_full;

endmodule

// File: tb/tb_lifo_stack.sv
// -----------------------------------------------------------------------------
// tb_lifo_stack
// Scoreboard bench: the driver applies stimulus on the falling edge and updates
// a queue-based stack model; every pop outcome is pushed to a scoreboard queue.
// A monitor samples 3 time units after each rising edge and compares.
// -----------------------------------------------------------------------------
module tb_lifo_stack;

    localparam int DW    = 8;
    localparam int DEP   = 16;
    localparam int PW    = $clog2(DEP) + 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          psh = 1'b0;
    logic          pop = 1'b0;
    logic [DW-1:0] d_in = '0;
    logic [DW-1:0] o;
    logic          popDone;
    logic [PW-1:0] count;
    logic          empty;
    logic          full;
`ifdef LIFO_STACK_ERR_EN
    logic          overflow;
    logic          underflow;
`endif

    lifo_stack #(.DATA_W(DW), .DEPTH(DEP)) dut (
        .clockSignal (clk),
        .reset       (reset),
        .psh         (psh),
        .pop         (pop),
        .d_in        (d_in),
        .o           (o),
        .popDone     (popDone),
        .count       (count),
        .empty       (empty),
        .full        (full)
`ifdef LIFO_STACK_ERR_EN
        ,
        .overflow    (overflow),
        .underflow   (underflow)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: state expected after the next rising edge.
    logic [DW-1:0] stk[$];
    logic [DW-1:0] sb[$];
    logic [DW-1:0] mdl_o = '0;
    logic          mdl_ovf = 1'b0;
    logic          mdl_unf = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic p, input logic q, input logic [DW-1:0] d);
        logic [DW-1:0] v;
        @(negedge clk);
        psh  = p;
        pop  = q;
        d_in = d;
        if (p && q) begin
            if (stk.size() > 0) begin
                v = stk[stk.size()-1];
                stk[stk.size()-1] = d;
            end else begin
                v = d;
            end
            mdl_o = v;
            sb.push_back(v);
        end else if (q) begin
            if (stk.size() > 0) mdl_o = stk.pop_back();
            else                mdl_unf = 1'b1;
            sb.push_back(mdl_o);
        end else if (p) begin
            if (stk.size() < DEP) stk.push_back(d);
            else                  mdl_ovf = 1'b1;
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        psh   = 1'b0;
        pop   = 1'b0;
        stk.delete();
        sb.delete();
        mdl_o   = '0;
        mdl_ovf = 1'b0;
        mdl_unf = 1'b0;
        #1;
        chk("rst_count",   int'(count),   0);
        chk("rst_o",       int'(o),       0);
        chk("rst_popDone", int'(popDone), 0);
        chk("rst_empty",   int'(empty),   1);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Monitor: pop results from the scoreboard, plus status every cycle
    initial begin
        logic [DW-1:0] e;
        forever begin
            @(posedge clk);
            #3;
            chk("popDone", int'(popDone), int'(sb.size() != 0));
            if (popDone && sb.size() != 0) begin
                e = sb.pop_front();
                chk("o_on_pop", int'(o), int'(e));
            end
            sb.delete();
            chk("o_hold", int'(o),     int'(mdl_o));
            chk("count",  int'(count), stk.size());
            chk("empty",  int'(empty), int'(stk.size() == 0));
            chk("full",   int'(full),  int'(stk.size() == DEP));
`ifdef LIFO_STACK_ERR_EN
            chk("overflow",  int'(overflow),  int'(mdl_ovf));
            chk("underflow", int'(underflow), int'(mdl_unf));
`endif
        end
    end

    initial begin
        int r;
        #1;
        chk("init_count",   int'(count),   0);
        chk("init_o",       int'(o),       0);
        chk("init_popDone", int'(popDone), 0);
        @(negedge clk);
        reset = 1'b0;

        // Push 0x00 then pop it; idle to see the pulse drop
        step(1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b0, 8'h00);

        // Push 3,5,7 then three back-to-back pops
        step(1'b1, 1'b0, 8'd3);
        step(1'b1, 1'b0, 8'd5);
        step(1'b1, 1'b0, 8'd7);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b0, 8'h00);

        // Increment idiom using the model's popped value
        step(1'b1, 1'b0, 8'd2);
        step(1'b0, 1'b1, 8'h00);
        step(1'b1, 1'b0, mdl_o + 8'd1);
        step(1'b0, 1'b1, 8'h00);

        // Fill, push while full, then pop the top
        for (int i = 0; i < DEP; i++) step(1'b1, 1'b0, DW'(i));
        step(1'b1, 1'b0, 8'hAA);
        step(1'b0, 1'b1, 8'h00);

        // Drain, then pop while empty
        for (int i = 0; i < DEP - 1; i++) step(1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b0, 8'h00);

        // Pass-through on empty, then replace-top
        step(1'b1, 1'b1, 8'h5C);
        step(1'b1, 1'b0, 8'd9);
        step(1'b1, 1'b1, 8'd4);
        step(1'b0, 1'b1, 8'h00);

        // Reset while a pop pulse is showing and data is stored
        step(1'b1, 1'b0, 8'd2);
        step(1'b1, 1'b0, 8'd2);
        step(1'b0, 1'b1, 8'h00);
        apply_reset();

        // Randomized traffic: push-heavy then pop-heavy
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 9);
            if (i < 200) begin
                if (r < 6)       step(1'b1, 1'b0, DW'($urandom));
                else if (r < 8)  step(1'b0, 1'b1, 8'h00);
                else if (r == 8) step(1'b1, 1'b1, DW'($urandom));
                else             step(1'b0, 1'b0, 8'h00);
            end else begin
                if (r < 3)       step(1'b1, 1'b0, DW'($urandom));
                else if (r < 8)  step(1'b0, 1'b1, 8'h00);
                else if (r == 8) step(1'b1, 1'b1, DW'($urandom));
                else             step(1'b0, 1'b0, 8'h00);
            end
        end
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'h00);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
